// File: rtl/display_pkg.sv
// display_pkg: shared constants, FSM encoding and nibble helper for the
// display_bcd_mux slice.
//   BCD_BLANK       - code the seven-segment decoder renders as all-off
//   *_DEF           - default DATA_W / DIGITS / REFRESH_DIV
//   conv_state_e    - converter FSM encoding (IDLE=0, CONVERT=1, DONE=2)
//   add3            - double-dabble nibble correction
package display_pkg;

  localparam int DATA_W_DEF      = 8;
  localparam int DIGITS_DEF      = 3;
  localparam int REFRESH_DIV_DEF = 1000;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } conv_state_e;

  // A nibble >= 5 would carry out after the next doubling, so pre-add 3.
  // Max result is 9+3=12, which still fits in 4 bits.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 binary to BCD converter.
// Ports:
//   i_clk      clock, rising edge
//   i_rst      asynchronous active-high reset
//   i_value    binary value, captured on a load edge in IDLE
//   i_load     start strobe; ignored unless IDLE
//   o_busy     high in CONVERT and DONE
//   o_bcd_out  BCD scratch register (digit 0 in bits [3:0])
//   o_valid    high during DONE; the edge that leaves DONE is the edge the
//              result is final, so consumers capture o_bcd_out on it
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_W-1:0]     i_value,
  input  logic                  i_load,
  output logic                  o_busy,
  output logic [4*DIGITS-1:0]   o_bcd_out,
  output logic                  o_valid
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  conv_state_e             r_state, w_state_nxt;
  logic [DATA_W-1:0]       r_bin;
  logic [4*DIGITS-1:0]     r_scr;
  logic [4*DIGITS-1:0]     w_scr_adj;
  logic [CNT_W-1:0]        r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_load) w_state_nxt = CONVERT;
      // Counter still holds 1 on the last shift edge.
      CONVERT: if (r_cnt == CNT_W'(1)) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_scr_adj = r_scr;
    for (int d = 0; d < DIGITS; d++)
      w_scr_adj[4*d +: 4] = add3(r_scr[4*d +: 4]);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bin <= '0;
      r_scr <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: if (i_load) begin
          r_bin <= i_value;
          r_scr <= '0;
          r_cnt <= CNT_W'(DATA_W);
        end
        CONVERT: begin
          // {scratch, binary} shifts left as one register.
          r_scr <= {w_scr_adj[4*DIGITS-2:0], r_bin[DATA_W-1]};
          r_bin <= {r_bin[DATA_W-2:0], 1'b0};
          r_cnt <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_busy    = (r_state != IDLE);
  assign o_valid   = (r_state == DONE);
  assign o_bcd_out = r_scr;

endmodule

// File: rtl/display_bcd_mux.sv
// display_bcd_mux: converts a binary value to BCD and time-multiplexes the
// digits onto one 4-bit bus for a shared seven-segment decoder.
// Ports:
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_value      binary value to display
//   i_load       single-cycle strobe: capture i_value, start conversion
//   o_busy       conversion in progress (loads dropped while high)
//   o_bcd        currently selected digit (BCD_BLANK when blanked)
//   o_digit_en   one-hot digit enable, bit 0 = ones
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits
// (ones digit never blanked). Default build shows every digit.
module display_bcd_mux
  import display_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DIGITS      = DIGITS_DEF,
  parameter int REFRESH_DIV = REFRESH_DIV_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [DATA_W-1:0]   i_value,
  input  logic                i_load,
  output logic                o_busy,
  output logic [3:0]          o_bcd,
  output logic [DIGITS-1:0]   o_digit_en
);

  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0]     w_scr;
  logic                    w_valid;
  logic [DIGITS-1:0][3:0]  r_disp;
  logic [DIGITS-1:0][3:0]  w_shown;
  logic [REF_W-1:0]        r_ref;
  logic [IDX_W-1:0]        r_idx, w_idx_nxt;
  logic                    w_ref_tc;
  logic [3:0]              r_bcd;
  logic [DIGITS-1:0]       r_en;

  bin2bcd_seq #(.DATA_W(DATA_W), .DIGITS(DIGITS)) u_conv (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_value   (i_value),
    .i_load    (i_load),
    .o_busy    (o_busy),
    .o_bcd_out (w_scr),
    .o_valid   (w_valid)
  );

  // All digits updated on one edge so a half-new value is never shown.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        r_disp <= '0;
    else if (w_valid) r_disp <= w_scr;
  end

  always_comb begin
    w_shown = r_disp;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic v_lead;
      v_lead = 1'b1;
      // Walk down from the top digit; blank while everything above is zero.
      for (int d = DIGITS - 1; d >= 1; d--) begin
        v_lead = v_lead && (r_disp[d] == 4'd0);
        if (v_lead) w_shown[d] = BCD_BLANK;
      end
    end
`endif
  end

  always_comb begin
    w_ref_tc  = (r_ref == REF_W'(REFRESH_DIV - 1));
    w_idx_nxt = r_idx;
    if (w_ref_tc)
      w_idx_nxt = (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
  end

  // Outputs are registered from the next index so bcd and digit_en move
  // together; a fresh display value shows up one cycle after it lands.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ref <= '0;
      r_idx <= '0;
      r_bcd <= '0;
      r_en  <= DIGITS'(1);
    end else begin
      r_ref <= w_ref_tc ? '0 : r_ref + 1'b1;
      r_idx <= w_idx_nxt;
      r_bcd <= w_shown[w_idx_nxt];
      r_en  <= DIGITS'(1) << w_idx_nxt;
    end
  end

  assign o_bcd      = r_bcd;
  assign o_digit_en = r_en;

endmodule

// File: tb/tb_display_bcd_mux.sv
module tb_display_bcd_mux;

  localparam int DW = 8;
  localparam int ND = 3;
  localparam int RD = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   value;
  logic            load;
  logic            busy;
  logic [3:0]      bcd;
  logic [ND-1:0]   digit_en;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_t, m_cd, m_disp, m_pend;
  int e_bcd, e_en;

  always #5 clk = ~clk;

  display_bcd_mux #(.DATA_W(DW), .DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_value    (value),
    .i_load     (load),
    .o_busy     (busy),
    .o_bcd      (bcd),
    .o_digit_en (digit_en)
  );

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Decimal digit k of v as the display should show it.
  function automatic int exp_digit(input int v, input int k);
    int p;
    p = 1;
    for (int i = 0; i < k; i++) p *= 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (k > 0 && v < p) return 15;
`endif
    return (v / p) % 10;
  endfunction

  task automatic model_reset();
    m_t = 0; m_cd = 0; m_disp = 0; m_pend = 0;
    e_bcd = 0; e_en = 1;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".busy"}, int'(busy), (m_cd > 0) ? 1 : 0);
    chk({tag, ".bcd"},  int'(bcd), e_bcd);
    chk({tag, ".en"},   int'(digit_en), e_en);
  endtask

  // One clock: advance model with inputs seen at the edge, check at negedge.
  task automatic step(input string tag);
    int idx;
    @(posedge clk);
    if (rst) model_reset();
    else begin
      m_t++;
      idx   = (m_t / RD) % ND;
      e_bcd = exp_digit(m_disp, idx);   // display as it was before this edge
      e_en  = 1 << idx;
      if (m_cd > 0) begin
        m_cd--;
        if (m_cd == 0) m_disp = m_pend;
      end else if (load) begin
        m_pend = int'(value);
        m_cd   = DW + 1;
      end
    end
    @(negedge clk);
    check_outs(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic do_load(input string tag, input int v);
    value = DW'(v);
    load  = 1'b1;
    step(tag);
    load  = 1'b0;
  endtask

  task automatic async_rst(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check_outs(tag);
    run(tag, 2);
    rst = 1'b0;
  endtask

  int vals[6] = '{255, 0, 100, 9, 7, 105};

  initial begin
    rst = 1'b1; load = 1'b0; value = '0;
    model_reset();
    #2;
    check_outs("por");
    @(negedge clk);
    run("rst_hold", 2);
    rst = 1'b0;
    run("idle_scan", 14);

    foreach (vals[i]) begin
      do_load("dir_load", vals[i]);
      run("dir_run", 21);
    end

    // Second load lands while busy and must be dropped.
    do_load("drop_a", 128);
    run("drop_b", 2);
    do_load("drop_c", 42);
    run("drop_d", 20);

    // Reset in the middle of a conversion.
    do_load("mid_a", 200);
    run("mid_b", 3);
    async_rst("mid_rst");
    run("mid_c", 15);
    do_load("mid_d", 200);
    run("mid_e", 21);

    // Async reset mid-slot with a nonzero display.
    run("slot", 2);
    async_rst("slot_rst");
    run("slot_after", 6);

    // Random loads, including loads while busy and back-to-back with DONE.
    for (int it = 0; it < 40; it++) begin
      do_load("rnd_load", $urandom_range(0, 255));
      for (int j = 0; j < int'($urandom_range(0, 24)); j++) begin
        if ($urandom_range(0, 3) == 0) do_load("rnd_extra", $urandom_range(0, 255));
        else step("rnd_run");
      end
    end
    run("tail", 24);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
